// File: rtl/apb_interconnect_pkg.sv
// Shared types and constants for the APB interconnect: FSM state encoding,
// the error read-data pattern and a width helper for the timeout counter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam logic [31:0] APB_ERR_DATA = 32'hDEADBEEF;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_interconnect_if.sv
// Bus bundle for the APB interconnect: upstream master port plus the
// fanned-out downstream slave port. The slave modport is the bridge's view,
// the master modport is the view of the surrounding system (CPU + slaves).
interface apb_interconnect_if #(
    parameter int N = 4
);
    logic            up_psel;
    logic            up_penable;
    logic            up_pwrite;
    logic [31:0]     up_paddr;
    logic [31:0]     up_pwdata;
    logic            up_pready;
    logic [31:0]     up_prdata;
    logic            up_pslverr;

    logic [N-1:0]    down_psel_vec;
    logic            down_penable;
    logic            down_pwrite;
    logic [31:0]     down_paddr;
    logic [31:0]     down_pwdata;
    logic [N-1:0]    down_pready_vec;
    logic [N-1:0]    down_pslverr_vec;
    logic [N*32-1:0] down_prdata_vec;

    modport slave (
        input  up_psel, up_penable, up_pwrite, up_paddr, up_pwdata,
        output up_pready, up_prdata, up_pslverr,
        output down_psel_vec, down_penable, down_pwrite, down_paddr, down_pwdata,
        input  down_pready_vec, down_pslverr_vec, down_prdata_vec
    );

    modport master (
        output up_psel, up_penable, up_pwrite, up_paddr, up_pwdata,
        input  up_pready, up_prdata, up_pslverr,
        input  down_psel_vec, down_penable, down_pwrite, down_paddr, down_pwdata,
        output down_pready_vec, down_pslverr_vec, down_prdata_vec
    );
endinterface

// File: rtl/apb_interconnect_addr_decode.sv
// Combinational slave decode: picks the slave index out of the address and
// flags whether that index names an existing slave.
module apb_addr_decode #(
    parameter int N       = 4,
    parameter int DEC_LSB = 16,
    parameter int DEC_W   = 2
) (
    input  logic [31:0]      addr,
    output logic [DEC_W-1:0] idx,
    output logic             valid
);
    // Bits outside the decode field are legitimately ignored here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    // Slice out the decode field and range-check it against N.
    always_comb begin
        idx   = addr[DEC_LSB +: DEC_W];
        valid = ({{(32-DEC_W){1'b0}}, idx} < 32'(N));
    end

endmodule

// File: rtl/apb_interconnect.sv
// Registered APB 1-to-N bridge. Every bus-facing output comes straight from a
// flop, so no combinational path exists between the two sides.
// Optional feature: define APB_INTERCONNECT_TIMEOUT_EN to bound the ACCESS
// phase to TIMEOUT_CYCLES cycles; otherwise ACCESS waits forever.
//
// state  | meaning
// IDLE   | waiting for an upstream access phase (psel & penable)
// SETUP  | downstream psel asserted, penable low, one cycle
// ACCESS | downstream psel+penable, waiting for the selected slave's ready
// RESP   | one-cycle upstream response (pready, prdata, pslverr)
module apb_interconnect
    import apb_pkg::*;
#(
    parameter int N              = 4,
    parameter int DEC_LSB        = 16,
    parameter int DEC_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    apb_interconnect_if.slave bus
);

    apb_state_t       state_q, state_d;

    logic [DEC_W-1:0] dec_idx;
    logic             dec_valid;

    logic [N-1:0]     psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic             pready_q, pready_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pslverr_q, pslverr_d;

    logic             sel_ready;
    logic             sel_err;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;

    apb_addr_decode #(
        .N       (N),
        .DEC_LSB (DEC_LSB),
        .DEC_W   (DEC_W)
    ) u_dec (
        .addr  (bus.up_paddr),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    // Responses of the selected slave only; the registered one-hot select
    // masks out everything the unselected slaves drive.
    always_comb begin
        sel_ready = |(bus.down_pready_vec & psel_q);
        sel_err   = |(bus.down_pslverr_vec & psel_q);
        sel_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (psel_q[i]) begin
                sel_rdata = sel_rdata | bus.down_prdata_vec[i*32 +: 32];
            end
        end
    end

`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt_q;

    // Counts ACCESS cycles without ready; cleared while in SETUP so it starts
    // at zero on entry to ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !sel_ready && !timeout_hit) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Keeps TIMEOUT_CYCLES referenced when the counter is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Upstream inputs are only looked at in IDLE, and RESP
    // always returns to IDLE, so the master samples pready before the FSM can
    // capture again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.up_psel && bus.up_penable) begin
                    state_d = dec_valid ? ST_SETUP : ST_RESP;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the output flops, keyed on the transition being taken.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pready_d  = 1'b0;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d != ST_IDLE) begin
                    paddr_d  = bus.up_paddr;
                    pwdata_d = bus.up_pwdata;
                    pwrite_d = bus.up_pwrite;
                    if (state_d == ST_SETUP) begin
                        for (int i = 0; i < N; i++) begin
                            psel_d[i] = (dec_idx == DEC_W'(i));
                        end
                        penable_d = 1'b0;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = APB_ERR_DATA;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (state_d == ST_RESP) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    if (sel_ready) begin
                        prdata_d  = pwrite_q ? 32'h0 : sel_rdata;
                        pslverr_d = sel_err;
                    end else begin
                        prdata_d  = APB_ERR_DATA;
                        pslverr_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.down_psel_vec = psel_q;
    assign bus.down_penable  = penable_q;
    assign bus.down_pwrite   = pwrite_q;
    assign bus.down_paddr    = paddr_q;
    assign bus.down_pwdata   = pwdata_q;
    assign bus.up_pready     = pready_q;
    assign bus.up_prdata     = prdata_q;
    assign bus.up_pslverr    = pslverr_q;

endmodule

// File: tb/tb_apb_interconnect.sv
// Self-checking bench for apb_interconnect. A 4-slave instance carries the
// main traffic; a 3-slave instance exercises the unmapped-address path.
module tb_apb_interconnect;

    localparam int T     = 8;
    localparam int NSLV  = 4;
    localparam int NEVER = 1000;
`ifdef APB_INTERCONNECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    apb_interconnect_if #(.N(4)) bi4 ();
    apb_interconnect_if #(.N(3)) bi3 ();

    apb_interconnect #(.N(4), .DEC_LSB(16), .DEC_W(2), .TIMEOUT_CYCLES(T)) u_dut4 (
        .clk (clk), .rst (rst), .bus (bi4.slave)
    );
    apb_interconnect #(.N(3), .DEC_LSB(16), .DEC_W(2), .TIMEOUT_CYCLES(T)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bi3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        bi4.up_psel = 0; bi4.up_penable = 0; bi4.up_pwrite = 0;
        bi4.up_paddr = 0; bi4.up_pwdata = 0;
        bi4.down_pready_vec = 0; bi4.down_pslverr_vec = 0; bi4.down_prdata_vec = '0;
        bi3.up_psel = 0; bi3.up_penable = 0; bi3.up_pwrite = 0;
        bi3.up_paddr = 0; bi3.up_pwdata = 0;
        bi3.down_pready_vec = 0; bi3.down_pslverr_vec = 0; bi3.down_prdata_vec = '0;
        repeat (2) @(negedge clk);
        if ({bi4.down_psel_vec, bi4.down_penable, bi4.down_pwrite} !== 6'b0) begin
            errors++; $display("FAIL reset_down_ctrl: got %b want 0", {bi4.down_psel_vec, bi4.down_penable, bi4.down_pwrite});
        end
        checks++;
        if ({bi4.down_paddr, bi4.down_pwdata} !== 64'h0) begin
            errors++; $display("FAIL reset_down_data: got %h want 0", {bi4.down_paddr, bi4.down_pwdata});
        end
        checks++;
        if ({bi4.up_pready, bi4.up_pslverr, bi4.up_prdata} !== 34'h0) begin
            errors++; $display("FAIL reset_up: got %h want 0", {bi4.up_pready, bi4.up_pslverr, bi4.up_prdata});
        end
        checks++;
        if ({bi3.up_pready, bi3.down_psel_vec} !== 4'h0) begin
            errors++; $display("FAIL reset_dut3: got %b want 0", {bi3.up_pready, bi3.down_psel_vec});
        end
        checks++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One complete transfer on the 4-slave instance. The target slave raises
    // ready in its (d+1)-th ACCESS cycle; every other slave drives noise.
    // Reference model: mapped reads/writes answer 3+d cycles after capture;
    // with the timeout built in, d >= T answers after 2+T cycles with an error;
    // without it, d >= NEVER never answers. Upstream noise is driven while the
    // transfer is in flight.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input int d, input logic serr, input logic [31:0] rdata, input string tag);
        int          tgt, exp_lat, exp_psel, exp_nrdy, budget, lat, nrdy, psel_cyc, acc;
        logic        mapped, to, exp_err, got_err, bad_psel, bad_down, rdy;
        logic [31:0] exp_data, got_data;
        logic [3:0]  m, r1, r2;

        tgt      = int'(addr[17:16]);
        mapped   = (tgt < NSLV);
        to       = TO_EN && mapped && (d >= T);
        exp_lat  = !mapped ? 1 : (to ? 2 + T : ((d >= NEVER) ? -1 : 3 + d));
        exp_data = (!mapped || to) ? 32'hDEADBEEF : (wr ? 32'h0 : rdata);
        exp_err  = (!mapped || to) ? 1'b1 : serr;
        budget   = (exp_lat < 0) ? 100 : exp_lat + 20;
        exp_psel = (exp_lat < 0) ? budget : exp_lat - 1;
        exp_nrdy = (exp_lat < 0) ? 0 : 1;
        m        = 4'(1 << tgt);

        @(negedge clk);
        bi4.up_psel = 1'b1; bi4.up_penable = 1'b0; bi4.up_pwrite = wr;
        bi4.up_paddr = addr; bi4.up_pwdata = wdata;
        bi4.down_pready_vec = 4'($urandom) & ~m;
        @(negedge clk);
        bi4.up_penable = 1'b1;

        lat = -1; nrdy = 0; psel_cyc = 0; acc = 0;
        bad_psel = 1'b0; bad_down = 1'b0; got_data = '0; got_err = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bi4.up_pready) begin
                nrdy++;
                if (lat < 0) begin
                    lat = c; got_data = bi4.up_prdata; got_err = bi4.up_pslverr;
                end
            end
            if (bi4.down_psel_vec != 4'b0) begin
                psel_cyc++;
                if (bi4.down_psel_vec != m) bad_psel = 1'b1;
                if (bi4.down_paddr !== addr || bi4.down_pwdata !== wdata || bi4.down_pwrite !== wr)
                    bad_down = 1'b1;
            end
            if (bi4.down_penable && ((bi4.down_psel_vec & m) != 4'b0)) acc++;
            rdy = bi4.down_penable && (acc >= d + 1);
            r1 = 4'($urandom); r2 = 4'($urandom);
            bi4.down_pready_vec  = (r1 & ~m) | (rdy ? m : 4'b0);
            bi4.down_pslverr_vec = (r2 & ~m) | (serr ? m : 4'b0);
            for (int s = 0; s < 4; s++)
                bi4.down_prdata_vec[s*32 +: 32] = (s == tgt) ? rdata : $urandom;
            if (lat > 0) begin
                bi4.up_psel = 1'b0; bi4.up_penable = 1'b0;
            end else begin
                bi4.up_psel = 1'($urandom); bi4.up_penable = 1'($urandom);
                bi4.up_pwrite = 1'($urandom); bi4.up_paddr = $urandom; bi4.up_pwdata = $urandom;
            end
            if (lat > 0 && c >= lat + 3) break;
        end
        bi4.up_psel = 1'b0; bi4.up_penable = 1'b0;
        bi4.down_pready_vec = 4'b0;

        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        end
        checks++;
        if (nrdy != exp_nrdy) begin
            errors++; $display("FAIL %s pready_count: got %0d want %0d", tag, nrdy, exp_nrdy);
        end
        checks++;
        if (psel_cyc != exp_psel) begin
            errors++; $display("FAIL %s psel_cycles: got %0d want %0d", tag, psel_cyc, exp_psel);
        end
        checks++;
        if (bad_psel !== 1'b0 || bad_down !== 1'b0) begin
            errors++; $display("FAIL %s down_side: bad_psel=%b bad_addr_data=%b want 0 0", tag, bad_psel, bad_down);
        end
        checks++;
        if (exp_lat > 0) begin
            if (got_data !== exp_data) begin
                errors++; $display("FAIL %s prdata: got %h want %h", tag, got_data, exp_data);
            end
            checks++;
            if (got_err !== exp_err) begin
                errors++; $display("FAIL %s pslverr: got %b want %b", tag, got_err, exp_err);
            end
            checks++;
        end
    endtask

    task automatic test_read();
        run_xfer(32'h0001_0010, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, "read_s1");
    endtask

    task automatic test_write_wait();
        run_xfer(32'h0003_0000, 1'b1, 32'hA5A5_A5A5, 4, 1'b0, 32'hFFFF_0000, "write_s3_wait");
    endtask

    task automatic test_slave_error();
        run_xfer(32'h0002_0000, 1'b0, 32'h0, 1, 1'b1, 32'h0, "slverr_s2");
    endtask

    task automatic test_boundary();
        run_xfer(32'h0000_0004, 1'b0, 32'h0, T - 1, 1'b0, 32'hCAFE_F00D, "ready_at_limit");
        run_xfer(32'h0001_0008, 1'b0, 32'h0, T, 1'b0, 32'h0BAD_CAFE, "ready_past_limit");
    endtask

    task automatic test_unmapped();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bi3.up_psel = 1'b1; bi3.up_penable = 1'b0; bi3.up_pwrite = 1'(k);
            bi3.up_paddr = 32'h0003_0000 + 32'(k * 4); bi3.up_pwdata = 32'h1111_2222;
            @(negedge clk);
            bi3.up_penable = 1'b1;
            @(negedge clk);
            if (bi3.up_pready !== 1'b1 || bi3.up_pslverr !== 1'b1) begin
                errors++; $display("FAIL unmapped%0d resp: pready=%b pslverr=%b want 1 1", k, bi3.up_pready, bi3.up_pslverr);
            end
            checks++;
            if (bi3.up_prdata !== 32'hDEADBEEF) begin
                errors++; $display("FAIL unmapped%0d prdata: got %h want deadbeef", k, bi3.up_prdata);
            end
            checks++;
            if (bi3.down_psel_vec !== 3'b0) begin
                errors++; $display("FAIL unmapped%0d psel: got %b want 000", k, bi3.down_psel_vec);
            end
            checks++;
            bi3.up_psel = 1'b0; bi3.up_penable = 1'b0;
            @(negedge clk);
            if (bi3.up_pready !== 1'b0 || bi3.down_psel_vec !== 3'b0) begin
                errors++; $display("FAIL unmapped%0d after: pready=%b psel=%b want 0 000", k, bi3.up_pready, bi3.down_psel_vec);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, w, r;
        logic        wr, se;
        int          d;
        for (int k = 0; k < 12; k++) begin
            a  = $urandom;
            wr = 1'($urandom);
            w  = $urandom;
            r  = $urandom;
            se = ($urandom_range(0, 3) == 0);
            d  = $urandom_range(0, 5);
            run_xfer(a, wr, w, d, se, r, $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_timeout();
        run_xfer(32'h0000_0000, 1'b0, 32'h0, NEVER, 1'b0, 32'h7777_7777, "never_ready");
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        bi4.up_psel = 1'b1; bi4.up_penable = 1'b0; bi4.up_pwrite = 1'b1;
        bi4.up_paddr = 32'h0000_0040; bi4.up_pwdata = 32'h5555_AAAA;
        bi4.down_pready_vec = 4'b0;
        @(negedge clk);
        bi4.up_penable = 1'b1;
        @(negedge clk);
        bi4.up_psel = 1'b0; bi4.up_penable = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        if ({bi4.down_psel_vec, bi4.down_penable, bi4.down_pwrite} !== 6'b0) begin
            errors++; $display("FAIL rst_access_ctrl: got %b want 0", {bi4.down_psel_vec, bi4.down_penable, bi4.down_pwrite});
        end
        checks++;
        if ({bi4.down_paddr, bi4.down_pwdata, bi4.up_prdata} !== 96'h0) begin
            errors++; $display("FAIL rst_access_data: got %h want 0", {bi4.down_paddr, bi4.down_pwdata, bi4.up_prdata});
        end
        checks++;
        if ({bi4.up_pready, bi4.up_pslverr} !== 2'b0) begin
            errors++; $display("FAIL rst_access_resp: got %b want 00", {bi4.up_pready, bi4.up_pslverr});
        end
        checks++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bi4.up_pready !== 1'b0 || bi4.down_psel_vec !== 4'b0) begin
                errors++; $display("FAIL rst_release_idle%0d: pready=%b psel=%b want 0 0000", c, bi4.up_pready, bi4.down_psel_vec);
            end
            checks++;
        end
        run_xfer(32'h0000_0100, 1'b0, 32'h0, 1, 1'b0, 32'h0F0F_1234, "read_after_reset");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_unmapped();
        test_slave_error();
        test_boundary();
        test_random();
        test_timeout();
        test_reset_in_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_interconnect.md
APB_INTERCONNECT -- requirements
Module: apb_interconnect

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
  - N, 4: number of downstream slaves, 1..16.
  - DEC_LSB, 16: lowest address bit used for slave decode; each slave window is 2**DEC_LSB bytes.
  - DEC_W, 2: width of the decode field; N <= 2**DEC_W.
  - TIMEOUT_CYCLES, 1024: ACCESS-phase wait limit, >= 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1: the single clock; all state changes on its rising edge.
  - rst, in, 1: reset, asynchronous, active-high.
  - up_psel, up_penable, up_pwrite, in, 1 each: APB master control.
  - up_paddr, up_pwdata, in, 32 each: master address and write data.
  - up_pready, out, 1: transfer complete.
  - up_prdata, out, 32: read data.
  - up_pslverr, out, 1: transfer error.
  - down_psel_vec, out, N: one-hot slave select.
  - down_penable, down_pwrite, out, 1 each: slave-side control.
  - down_paddr, down_pwdata, out, 32 each: slave-side address and write data.
  - down_pready_vec, in, N: per-slave ready.
  - down_pslverr_vec, in, N: per-slave error.
  - down_prdata_vec, in, N*32: per-slave read data; slave i at bits [i*32 +: 32].

Function
REQ-003 The block SHALL be a registered APB bridge: every downstream output and every upstream response output SHALL be driven from flops, with no combinational path from up_* to down_* or from down_* to up_*.
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS and RESP.
REQ-005 IDLE: when up_psel=1 and up_penable=1 at a clock edge, the block SHALL capture up_paddr, up_pwdata and up_pwrite, and decode idx = up_paddr[DEC_LSB +: DEC_W].
REQ-006 IDLE with idx < N SHALL go to SETUP: down_psel_vec[idx]=1, down_penable=0, down_* address/data/write driven from the captured values.
REQ-007 IDLE with idx >= N (unmapped) SHALL go directly to RESP with up_pslverr=1 and up_prdata=32'hDEADBEEF; no down_psel bit asserts.
REQ-008 SETUP SHALL last exactly one cycle, then go to ACCESS with down_penable=1 and down_psel_vec held.
REQ-009 ACCESS: on the edge where down_pready_vec[idx]=1, the block SHALL capture down_prdata_vec slice idx and down_pslverr_vec[idx], clear down_psel_vec and down_penable, and go to RESP.
REQ-010 RESP SHALL last exactly one cycle with up_pready=1 and the captured up_prdata/up_pslverr, then go to IDLE.
REQ-011 up_pready SHALL be 0 in every state except RESP.
REQ-012 Minimum latency: capture edge E0, SETUP, ACCESS (slave ready at E2), up_pready=1 in the cycle after E2, i.e. 3 cycles after E0.
REQ-013 On writes, up_prdata SHALL be 0 in RESP.
REQ-014 Upstream inputs SHALL be ignored outside IDLE, including up_psel deasserted mid-transfer; the in-flight transfer completes normally.
REQ-015 The master's completed transfer SHALL NOT be re-captured: the FSM re-enters IDLE only after the edge at which the master samples up_pready.
REQ-016 down_pready_vec and down_pslverr_vec bits of unselected slaves SHALL be ignored.

Reset
REQ-017 While rst=1, regardless of clk, the block SHALL force state=IDLE, down_psel_vec=0, down_penable=0, down_pwrite=0, down_paddr=0, down_pwdata=0, up_pready=0, up_prdata=0, up_pslverr=0, and the timeout counter to 0.
REQ-018 Reset asserted mid-transfer SHALL abort the transfer with no response; after release the block SHALL wait in IDLE for a fresh access phase.

Configuration
REQ-019 With APB_INTERCONNECT_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without slave ready.
REQ-020 If that counter reaches TIMEOUT_CYCLES-1 without slave ready, the block SHALL drop down_psel_vec/down_penable and go to RESP with up_pslverr=1 and up_prdata=32'hDEADBEEF.
REQ-021 If slave ready arrives on the same edge as the limit, ready SHALL win.
REQ-022 Without APB_INTERCONNECT_TIMEOUT_EN, there SHALL be no counter and ACCESS SHALL wait indefinitely; TIMEOUT_CYCLES is then unused.

Structure
REQ-023 Package apb_pkg SHALL hold the FSM state enum, the constant APB_ERR_DATA = 32'hDEADBEEF and the counter-width function clog2(TIMEOUT_CYCLES).
REQ-024 Address decode (idx plus valid flag) SHALL be a combinational sub-module apb_addr_decode with parameters N, DEC_LSB and DEC_W.

Verification
REQ-025 Read: addr 0x0001_0010, slave 1 ready immediately with prdata 0x1234_5678 -> down_psel_vec=4'b0010 for 2 cycles, up_pready 3 cycles after capture, up_prdata=0x1234_5678, up_pslverr=0.
REQ-026 Write with wait states: addr 0x0003_0000, wdata 0xA5A5_A5A5, slave 3 ready after 5 ACCESS cycles -> down_pwdata=0xA5A5_A5A5, up_pready exactly once, up_prdata=0.
REQ-027 Unmapped access: N=3, addr 0x0003_0000 -> no down_psel bit, up_pready one cycle after capture, up_pslverr=1, up_prdata=0xDEADBEEF.
REQ-028 Timeout (macro on, TIMEOUT_CYCLES=8): slave 0 never ready -> down_psel drops after 8 ACCESS cycles, up_pslverr=1, up_prdata=0xDEADBEEF; with the macro off the bench observes no response for 100 cycles.
REQ-029 Slave error: slave 2 returns pslverr=1 with prdata 0x0 -> up_pslverr=1 for the single RESP cycle.
REQ-030 Reset in ACCESS: assert rst between edges -> all outputs 0 immediately, no up_pready; a following read to slave 0 completes normally.
